truth_table_scanner: RTL and testbench

- Drives every minterm of an N_VARS-input registered Boolean block (a D flip-flop fed by a simplified SOP) once per clock.
- Reads back the block's registered output and assembles the observed truth table.
- Compares the table against a parameterised expected mask and reports match, mismatch count and first failing minterm.
- It is the stimulus/reader counterpart to the registered-function blocks. It replaces hand-written per-minterm testbench sequences.

---
 rtl/truth_table_scanner.sv | 140 ++++++++++++++
 tb/tb_truth_table_scanner.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
// Truth-table scanner: walks every minterm of an N_VARS-input registered
// function, captures the function's output LAT+1 edges after each minterm is
// driven, and compares the assembled table against EXPECTED.
module truth_table_scanner #(
    parameter int unsigned                N_VARS   = 4,
    parameter int unsigned                LAT      = 1,
    parameter logic [(2**N_VARS)-1:0]     EXPECTED = 16'h6EEE
) (
    input  logic                     clk,
    input  logic                     clr_n,
    input  logic                     start,
    input  logic                     f_in,
    output logic [N_VARS-1:0]        vars,
    output logic                     busy,
    output logic                     done,
    output logic [(2**N_VARS)-1:0]   table_out,
    output logic                     match,
    output logic [N_VARS:0]          err_count,
    output logic [N_VARS-1:0]        first_fail
);

    localparam int unsigned          M       = 2**N_VARS;
    localparam logic [N_VARS-1:0]    LAST_MT = '1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_nxt;

    // Capture pipeline: stage 0 holds the minterm driven at the current edge;
    // stage LAT names the minterm whose response is on f_in right now.
    logic              pipe_v   [0:LAT];
    logic [N_VARS-1:0] pipe_idx [0:LAT];

    logic              accept;
    logic              push;
    logic [N_VARS-1:0] push_idx;
    logic              last_cap;
    logic [M-1:0]      cap_table;
    logic [M-1:0]      diff;
    logic [N_VARS:0]   cnt;
    logic [N_VARS-1:0] ff_idx;
    logic              found;

    assign accept   = (state == IDLE) && start;
    assign push     = accept || ((state == SCAN) && (vars != LAST_MT));
    assign push_idx = accept ? '0 : vars + 1'b1;
    assign last_cap = pipe_v[LAT] && (pipe_idx[LAT] == LAST_MT);

    assign busy = (state == SCAN) || (state == DRAIN);
    assign done = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)              state_nxt = SCAN;
            SCAN:    if (vars == LAST_MT)    state_nxt = DRAIN;
            DRAIN:   if (last_cap)           state_nxt = DONE;
            DONE:                            state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    // Table as it will look after this edge's capture, and its comparison
    // against EXPECTED, so results land on the same edge as the final capture
    always_comb begin
        cap_table = table_out;
        if (pipe_v[LAT]) begin
            cap_table[pipe_idx[LAT]] = f_in;
        end
        diff   = cap_table ^ EXPECTED;
        cnt    = '0;
        ff_idx = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < M; i++) begin
            cnt = cnt + {{N_VARS{1'b0}}, diff[i]};
            if (diff[i] && !found) begin
                found  = 1'b1;
                ff_idx = N_VARS'(i);
            end
        end
    end

    // Minterm driver, capture pipeline, table and result registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            vars       <= '0;
            table_out  <= '0;
            match      <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
            for (int unsigned i = 0; i <= LAT; i++) begin
                pipe_v[i]   <= 1'b0;
                pipe_idx[i] <= '0;
            end
        end else begin
            pipe_v[0]   <= push;
            pipe_idx[0] <= push_idx;
            for (int unsigned i = 1; i <= LAT; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end

            if (accept) begin
                vars       <= '0;
                table_out  <= '0;
                match      <= 1'b0;
                err_count  <= '0;
                first_fail <= '0;
            end else begin
                if ((state == SCAN) && (vars != LAST_MT)) begin
                    vars <= vars + 1'b1;
                end
                if (pipe_v[LAT]) begin
                    table_out <= cap_table;
                end
                if (last_cap) begin
                    match      <= (diff == '0);
                    err_count  <= cnt;
                    first_fail <= ff_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: emulated registered functions feed two
// scanners (LAT=1 and LAT=2); fixed vectors, random tables, reset abort and
// held-start sequences are checked against values derived from the SOP.
module tb_truth_table_scanner;

    localparam int unsigned M = 16;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        f_in1, f_in2;
    logic [3:0]  vars1, vars2;
    logic        busy1, busy2, done1, done2, match1, match2;
    logic [15:0] tbl1, tbl2;
    logic [4:0]  err1, err2;
    logic [3:0]  ff1, ff2;

    int          errors = 0;
    int          checks = 0;
    int          mode = 0;
    bit          sel = 1'b0;
    logic [15:0] rtab = '0;

    always #5 clk = ~clk;

    truth_table_scanner #(.N_VARS(4), .LAT(1), .EXPECTED(16'h6EEE)) u_dut1 (
        .clk(clk), .clr_n(clr_n), .start(start), .f_in(f_in1),
        .vars(vars1), .busy(busy1), .done(done1), .table_out(tbl1),
        .match(match1), .err_count(err1), .first_fail(ff1)
    );

    truth_table_scanner #(.N_VARS(4), .LAT(2), .EXPECTED(16'h6EEE)) u_dut2 (
        .clk(clk), .clr_n(clr_n), .start(start2), .f_in(f_in2),
        .vars(vars2), .busy(busy2), .done(done2), .table_out(tbl2),
        .match(match2), .err_count(err2), .first_fail(ff2)
    );

    // Default function from its sum-of-products definition (a = MSB, d = LSB)
    function automatic bit fref(input logic [3:0] m);
        bit a, b, c, d;
        a = m[3]; b = m[2]; c = m[1]; d = m[0];
        return (~c & d) | (c & ~d) | (~a & d) | (~b & d);
    endfunction

    // Emulated functions under test: one- and two-stage registered blocks
    bit s1 = 1'b0, s2 = 1'b0, t1 = 1'b0, t2 = 1'b0;
    always @(posedge clk) begin
        s1 <= (mode == 5) ? rtab[vars1] : fref(vars1);
        s2 <= s1;
        t1 <= fref(vars2);
        t2 <= t1;
    end

    always_comb begin
        case (mode)
            1:       f_in1 = ~s1;
            2:       f_in1 = 1'b1;
            3:       f_in1 = 1'b0;
            4:       f_in1 = s2;
            default: f_in1 = s1;
        endcase
    end
    assign f_in2 = t2;

    logic        o_busy, o_done, o_match;
    logic [3:0]  o_vars, o_ff;
    logic [15:0] o_tbl;
    logic [4:0]  o_err;
    assign o_busy  = sel ? busy2  : busy1;
    assign o_done  = sel ? done2  : done1;
    assign o_match = sel ? match2 : match1;
    assign o_vars  = sel ? vars2  : vars1;
    assign o_ff    = sel ? ff2    : ff1;
    assign o_tbl   = sel ? tbl2   : tbl1;
    assign o_err   = sel ? err2   : err1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_results(input string tag, input logic [15:0] t, input bit m,
                               input int e, input int f);
        chk({tag, "_table"}, o_tbl, t);
        chk({tag, "_match"}, o_match, m);
        chk({tag, "_err_count"}, o_err, e);
        chk({tag, "_first_fail"}, o_ff, f);
    endtask

    // One scan: accept, follow vars, time done, confirm the one-cycle pulse.
    // poke re-asserts start mid-scan, which must change nothing.
    task automatic scan(input bit use2, input bit poke, input string tag);
        int  edges;
        int  lat;
        int  expv;
        bit  seq_ok;
        sel = use2;
        lat = use2 ? 2 : 1;
        @(negedge clk);
        if (use2) start2 = 1'b1; else start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        start2 = 1'b0;
        chk({tag, "_busy_after_accept"}, o_busy, 1'b1);
        edges  = 0;
        seq_ok = 1'b1;
        while (!o_done && edges < 100) begin
            expv = (edges < 16) ? edges : 15;
            if (o_vars !== 4'(expv)) seq_ok = 1'b0;
            if (poke) begin
                if (edges == 5) begin
                    if (use2) start2 = 1'b1; else start = 1'b1;
                end else begin
                    start = 1'b0; start2 = 1'b0;
                end
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        start = 1'b0; start2 = 1'b0;
        chk({tag, "_vars_seq"}, seq_ok, 1'b1);
        chk({tag, "_done_latency"}, edges, M + lat);
        chk({tag, "_busy_at_done"}, o_busy, 1'b0);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, o_done, 1'b0);
    endtask

    typedef struct {
        int          mode;
        logic [15:0] tbl;
        bit          m;
        int          err;
        int          ff;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          rerr, rff, w;
        bit          rfound;
        int          pulses [$];
        int          cyc;

        vecs[0] = '{0, 16'h6EEE, 1'b1, 0,  0};
        vecs[1] = '{1, 16'h9111, 1'b0, 16, 0};
        vecs[2] = '{2, 16'hFFFF, 1'b0, 5,  0};
        vecs[3] = '{3, 16'h0000, 1'b0, 11, 1};
        vecs[4] = '{4, 16'hDDDC, 1'b0, 8,  1};

        // Reset state
        #12;
        chk("reset_dut1", {vars1, busy1, done1, tbl1, match1, err1, ff1}, '0);
        chk("reset_dut2", {vars2, busy2, done2, tbl2, match2, err2, ff2}, '0);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fixed function variants against the LAT=1 scanner
        for (int i = 0; i < 5; i++) begin
            mode = vecs[i].mode;
            scan(1'b0, 1'b0, $sformatf("vec%0d", i));
            chk_results($sformatf("vec%0d", i), vecs[i].tbl, vecs[i].m, vecs[i].err, vecs[i].ff);
        end

        // Results hold while idle
        repeat (5) @(negedge clk);
        chk("hold_table", o_tbl, 16'hDDDC);
        chk("hold_vars", o_vars, 4'hF);

        // LAT=2 scanner against the two-stage block
        scan(1'b1, 1'b0, "lat2");
        chk_results("lat2", 16'h6EEE, 1'b1, 0, 0);

        // start pulsed mid-scan is ignored
        mode = 0;
        scan(1'b0, 1'b1, "poke");
        chk_results("poke", 16'h6EEE, 1'b1, 0, 0);

        // Random truth tables against the SOP-derived reference
        for (int r = 0; r < 6; r++) begin
            mode = 5;
            rtab = 16'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rerr = 0; rff = 0; rfound = 1'b0;
            for (int m = 0; m < 16; m++) begin
                if (rtab[m] != fref(4'(m))) begin
                    rerr++;
                    if (!rfound) begin rfound = 1'b1; rff = m; end
                end
            end
            scan(1'b0, 1'b0, $sformatf("rnd%0d", r));
            chk_results($sformatf("rnd%0d", r), rtab, (rerr == 0), rerr, rff);
        end

        // Asynchronous reset mid-scan, then a full clean scan
        mode = 0;
        sel  = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (vars1 !== 4'd7 && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("reach_vars7", vars1, 4'd7);
        #2 clr_n = 1'b0;
        #1;
        chk("reset_abort", {vars1, busy1, done1, tbl1, match1, err1, ff1}, '0);
        @(negedge clk);
        clr_n = 1'b1;
        scan(1'b0, 1'b0, "after_reset");
        chk_results("after_reset", 16'h6EEE, 1'b1, 0, 0);

        // start held high: back-to-back scans, done pulses 19 cycles apart
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done1) pulses.push_back(cyc);
        end
        start = 1'b0;
        chk("held_pulse_count", pulses.size(), 3);
        for (int p = 1; p < pulses.size(); p++) begin
            chk($sformatf("held_gap%0d", p), pulses[p] - pulses[p-1], 19);
        end
        repeat (40) @(negedge clk);
        chk("held_final_table", tbl1, 16'h6EEE);
        chk("held_final_idle", {busy1, done1}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
